// File: rtl/increment_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : increment_pipe
//  Description : Pipelined +1 / -1 unit with wrap or saturate overflow policy,
//                overflow flag, STAGES-deep register pipeline and valid/ready
//                handshake with full back-pressure and bubble compression.
//  Revision    : 1.0 - initial release
// ============================================================================
module increment_pipe #(
  parameter int W      = 32,  // operand/result width, W >= 2
  parameter int STAGES = 2,   // number of register stages, 1..4
  parameter int SAT    = 0    // 0 = wrap modulo 2^W, 1 = clamp at range limit
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_vld,
  input  logic [W-1:0] in_x,
  input  logic         in_dec,
  output logic         in_rdy,
  output logic         out_vld,
  output logic [W-1:0] out_y,
  output logic         out_ovf,
  input  logic         out_rdy
);

  // Stage-0 arithmetic
  logic [W-1:0]             w_mask;
  logic [W-1:0]             w_y;
  logic                     w_ovf;

  // Pipeline control and storage; index STAGES-1 is the output stage
  logic [STAGES-1:0]        w_adv;
  logic [STAGES-1:0]        r_vld;
  logic [STAGES-1:0]        r_ovf;
  logic [STAGES-1:0][W-1:0] r_y;

  // Toggle mask: the run of bits equal to the "carry" polarity (ones for
  // increment, zeros for decrement) starting at bit 0, plus the next bit up.
  // A bit continues the run when x[i] differs from in_dec.
  always_comb begin
    w_mask    = '0;
    w_mask[0] = 1'b1;
    for (int i = 1; i < W; i++) begin
      w_mask[i] = w_mask[i-1] & (in_x[i-1] ^ in_dec);
    end
    // Overflow when every bit is in the carry polarity: all-ones for
    // increment, all-zeros for decrement.
    w_ovf = &(in_x ^ {W{in_dec}});
    // Saturation at either limit is simply the unchanged operand.
    if ((SAT != 0) && w_ovf) begin
      w_y = in_x;
    end else begin
      w_y = in_x ^ w_mask;
    end
  end

  // Advance enables: stage i may move when it is empty, when some stage
  // downstream of it is empty (bubble compression), or when the consumer
  // takes the result. Written as a running AND over the tail of the pipe
  // so there is no self-referential vector in the logic.
  always_comb begin
    logic w_tail_full;
    w_tail_full = 1'b1;
    w_adv       = '0;
    for (int i = STAGES - 1; i >= 0; i--) begin
      w_tail_full = w_tail_full & r_vld[i];
      w_adv[i]    = out_rdy | ~w_tail_full;
    end
  end

  // Stage registers: stage 0 captures the arithmetic result, later stages
  // capture their predecessor; every stage loads only when it advances.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_vld <= '0;
      r_ovf <= '0;
      r_y   <= '0;
    end else begin
      if (w_adv[0]) begin
        r_vld[0] <= in_vld;
        r_y[0]   <= w_y;
        r_ovf[0] <= w_ovf;
      end
      for (int i = 1; i < STAGES; i++) begin
        if (w_adv[i]) begin
          r_vld[i] <= r_vld[i-1];
          r_y[i]   <= r_y[i-1];
          r_ovf[i] <= r_ovf[i-1];
        end
      end
    end
  end

  // Handshake outputs; in_rdy is combinational from out_rdy through the
  // advance chain, the result outputs come straight from the last stage.
  assign in_rdy  = w_adv[0];
  assign out_vld = r_vld[STAGES-1];
  assign out_y   = r_y[STAGES-1];
  assign out_ovf = r_ovf[STAGES-1];

endmodule
`default_nettype wire

// File: tb/tb_increment_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : tb_increment_pipe
//  Description : Self-checking bench for increment_pipe. Five instances share
//                one stimulus stream: (W,STAGES,SAT) = (8,2,0) (8,2,1) (8,1,1)
//                (8,4,0) (2,2,0). A queue scoreboard per instance checks
//                every transfer against an arithmetic reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_increment_pipe;

  localparam int NI = 5;
  localparam int IW   [NI] = '{8, 8, 8, 8, 2};
  localparam int ISAT [NI] = '{0, 1, 1, 0, 0};

  logic       clk = 1'b0;
  logic       rst;
  logic       in_vld;
  logic [7:0] in_x;
  logic       in_dec;
  logic       out_rdy;

  logic [NI-1:0] rdy;
  logic [NI-1:0] ovld;
  logic [NI-1:0] oovf;
  logic [7:0]    oy [NI];
  logic [7:0]    oy_a, oy_b, oy_c, oy_d;
  logic [1:0]    oy_e;

  int checks   = 0;
  int failures = 0;

  logic [8:0] q [NI][$];     // expected {ovf, y} per instance
  logic [8:0] a_out [$];     // results taken from instance 0
  logic [NI-1:0] hold;
  logic [8:0] prev [NI];
  int acc [NI];

  always #5 clk = ~clk;

  increment_pipe #(.W(8), .STAGES(2), .SAT(0)) u_a (
    .clk(clk), .rst(rst), .in_vld(in_vld), .in_x(in_x), .in_dec(in_dec),
    .in_rdy(rdy[0]), .out_vld(ovld[0]), .out_y(oy_a), .out_ovf(oovf[0]), .out_rdy(out_rdy));
  increment_pipe #(.W(8), .STAGES(2), .SAT(1)) u_b (
    .clk(clk), .rst(rst), .in_vld(in_vld), .in_x(in_x), .in_dec(in_dec),
    .in_rdy(rdy[1]), .out_vld(ovld[1]), .out_y(oy_b), .out_ovf(oovf[1]), .out_rdy(out_rdy));
  increment_pipe #(.W(8), .STAGES(1), .SAT(1)) u_c (
    .clk(clk), .rst(rst), .in_vld(in_vld), .in_x(in_x), .in_dec(in_dec),
    .in_rdy(rdy[2]), .out_vld(ovld[2]), .out_y(oy_c), .out_ovf(oovf[2]), .out_rdy(out_rdy));
  increment_pipe #(.W(8), .STAGES(4), .SAT(0)) u_d (
    .clk(clk), .rst(rst), .in_vld(in_vld), .in_x(in_x), .in_dec(in_dec),
    .in_rdy(rdy[3]), .out_vld(ovld[3]), .out_y(oy_d), .out_ovf(oovf[3]), .out_rdy(out_rdy));
  increment_pipe #(.W(2), .STAGES(2), .SAT(0)) u_e (
    .clk(clk), .rst(rst), .in_vld(in_vld), .in_x(in_x[1:0]), .in_dec(in_dec),
    .in_rdy(rdy[4]), .out_vld(ovld[4]), .out_y(oy_e), .out_ovf(oovf[4]), .out_rdy(out_rdy));

  assign oy[0] = oy_a;
  assign oy[1] = oy_b;
  assign oy[2] = oy_c;
  assign oy[3] = oy_d;
  assign oy[4] = {6'b0, oy_e};

  // Reference: true x+1 / x-1 in integer arithmetic, then apply the policy.
  function automatic logic [8:0] model(input int x, input logic dec, input int w, input int sat);
    int maxv;
    int v;
    int r;
    logic o;
    maxv = (1 << w) - 1;
    x    = x & maxv;
    v    = dec ? x - 1 : x + 1;
    o    = (v < 0) || (v > maxv);
    if (o) r = (sat != 0) ? x : (v & maxv);
    else   r = v;
    return {o, r[7:0]};
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Scoreboard: sampled on the falling edge, where handshake signals are
  // settled for the coming rising edge.
  always @(negedge clk) begin
    if (rst) begin
      for (int k = 0; k < NI; k++) q[k].delete();
      hold = '0;
    end else begin
      for (int k = 0; k < NI; k++) begin
        if (hold[k]) chk($sformatf("stall_hold%0d", k), {23'b0, oovf[k], oy[k]}, {23'b0, prev[k]});
        if (ovld[k] && out_rdy) begin
          chk($sformatf("no_extra%0d", k), {31'b0, q[k].size() != 0}, 32'd1);
          if (q[k].size() != 0)
            chk($sformatf("sb%0d", k), {23'b0, oovf[k], oy[k]}, {23'b0, q[k].pop_front()});
          if (k == 0) a_out.push_back({oovf[0], oy[0]});
        end
        if (in_vld && rdy[k]) q[k].push_back(model(int'(in_x), in_dec, IW[k], ISAT[k]));
        hold[k] = ovld[k] && !out_rdy;
        prev[k] = {oovf[k], oy[k]};
      end
    end
  end

  // Watchdog so the run always ends.
  initial begin
    #1000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic drain(input int n);
    in_vld  = 1'b0;
    out_rdy = 1'b1;
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Single operand into an empty pipe: checks acceptance and 2-cycle latency
  // on the STAGES=2 instances (0: wrap, 1: saturate).
  task automatic send_one(input logic [7:0] x, input logic dec,
                          input logic [7:0] ya, input logic oa,
                          input logic [7:0] yb, input logic ob);
    in_vld = 1'b1; in_x = x; in_dec = dec; out_rdy = 1'b1;
    @(negedge clk);
    chk("acc_rdy", {31'b0, rdy[0]}, 32'd1);
    @(posedge clk); #1;
    in_vld = 1'b0;
    @(negedge clk);
    chk("lat_early", {31'b0, ovld[0]}, 32'd0);
    @(negedge clk);
    chk("lat_vld", {31'b0, ovld[0]}, 32'd1);
    chk("wrap_y", {24'b0, oy[0]}, {24'b0, ya});
    chk("wrap_ovf", {31'b0, oovf[0]}, {31'b0, oa});
    chk("sat_y", {24'b0, oy[1]}, {24'b0, yb});
    chk("sat_ovf", {31'b0, oovf[1]}, {31'b0, ob});
    @(posedge clk); #1;
  endtask

  initial begin
    int cur;
    int cyc;
    logic accepted;
    rst = 1'b1; in_vld = 1'b0; in_x = '0; in_dec = 1'b0; out_rdy = 1'b0;
    hold = '0;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_vld", {27'b0, ovld}, 32'd0);
    chk("rst_y", {24'b0, oy[0]}, 32'd0);
    chk("rst_ovf", {31'b0, oovf[0]}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Directed values and boundaries
    send_one(8'h7F, 1'b0, 8'h80, 1'b0, 8'h80, 1'b0);
    send_one(8'h80, 1'b1, 8'h7F, 1'b0, 8'h7F, 1'b0);
    send_one(8'hFF, 1'b0, 8'h00, 1'b1, 8'hFF, 1'b1);
    send_one(8'h00, 1'b1, 8'hFF, 1'b1, 8'h00, 1'b1);
    send_one(8'hFE, 1'b0, 8'hFF, 1'b0, 8'hFF, 1'b0);
    drain(8);

    // Fill with consumer stalled: each pipe accepts exactly STAGES operands
    for (int k = 0; k < NI; k++) acc[k] = 0;
    out_rdy = 1'b0; in_vld = 1'b1; in_x = 8'h40; in_dec = 1'b0;
    repeat (6) begin
      @(negedge clk);
      for (int k = 0; k < NI; k++) if (rdy[k]) acc[k]++;
      @(posedge clk); #1;
    end
    chk("fill_cnt_s2", acc[0], 32'd2);
    chk("fill_cnt_s1", acc[2], 32'd1);
    chk("fill_cnt_s4", acc[3], 32'd4);
    chk("full_rdy_low", {31'b0, rdy[0]}, 32'd0);
    drain(8);

    // Back-pressure stream 0x10..0x17 with random consumer readiness
    a_out.delete();
    cur = 8'h10; cyc = 0; in_dec = 1'b0;
    while (cur <= 8'h17 && cyc < 200) begin
      in_vld = 1'b1; in_x = cur[7:0]; out_rdy = 1'($urandom % 2);
      @(negedge clk);
      accepted = rdy[0];
      @(posedge clk); #1;
      if (accepted) cur++;
      cyc++;
    end
    chk("bp_budget", cur, 32'h18);
    drain(8);
    chk("bp_count", a_out.size(), 32'd8);
    for (int i = 0; i < 8 && i < a_out.size(); i++)
      chk($sformatf("bp_out%0d", i), {23'b0, a_out[i]}, 32'h11 + i);

    // Full rate: one operand per cycle, one result per cycle
    a_out.delete();
    out_rdy = 1'b1; in_dec = 1'b0;
    for (int x = 0; x < 256; x++) begin
      in_vld = 1'b1; in_x = 8'(x);
      @(negedge clk);
      chk("rate_rdy", {31'b0, rdy[0]}, 32'd1);
      @(posedge clk); #1;
    end
    drain(8);
    chk("rate_count", a_out.size(), 32'd256);
    for (int i = 0; i < 256 && i < a_out.size(); i++)
      chk("rate_out", {23'b0, a_out[i]}, {23'b0, (i == 255), 8'(i + 1)});

    // Reset with two results in flight
    out_rdy = 1'b0; in_vld = 1'b1; in_x = 8'h33; in_dec = 1'b0;
    repeat (2) @(posedge clk);
    #1 in_vld = 1'b0;
    @(negedge clk);
    chk("pre_rst_vld", {31'b0, ovld[0]}, 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_vld", {27'b0, ovld}, 32'd0);
    chk("mid_rst_y", {24'b0, oy[0]}, 32'd0);
    chk("mid_rst_ovf", {31'b0, oovf[0]}, 32'd0);
    @(negedge clk);
    @(posedge clk); #1;
    rst = 1'b0;
    send_one(8'h05, 1'b1, 8'h04, 1'b0, 8'h04, 1'b0);
    drain(8);

    // Randomised traffic, biased toward the range limits
    for (int n = 0; n < 400; n++) begin
      in_vld = ($urandom % 4) != 0;
      case ($urandom % 4)
        0:       in_x = 8'h00;
        1:       in_x = 8'hFF;
        default: in_x = 8'($urandom);
      endcase
      in_dec  = 1'($urandom % 2);
      out_rdy = ($urandom % 3) != 0;
      @(posedge clk); #1;
    end
    drain(12);
    for (int k = 0; k < NI; k++)
      chk($sformatf("drained%0d", k), q[k].size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
